// File: rtl/eth_st_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_st_pkg
// Purpose  : Shared widths and beat structures for the Ethernet Avalon-ST
//            packet path (64-bit per-port side and 128-bit ingress side).
// Contents : IN_W / OUT_W data widths, CH_W channel width, empty widths,
//            st_beat64_t and st_beat128_t packed beat records.
// Revision : 1.0 - initial release
// ============================================================================
package eth_st_pkg;

  localparam int IN_W        = 64;   // 8 byte symbols per input beat
  localparam int OUT_W       = 128;  // 16 byte symbols per output beat
  localparam int CH_W        = 10;
  localparam int IN_EMPTY_W  = 3;    // log2(8)
  localparam int OUT_EMPTY_W = 4;    // log2(16)

  typedef struct packed {
    logic [IN_W-1:0]       data;
    logic [CH_W-1:0]       channel;
    logic                  sop;
    logic                  eop;
    logic [IN_EMPTY_W-1:0] empty;
  } st_beat64_t;

  typedef struct packed {
    logic [OUT_W-1:0]       data;
    logic [CH_W-1:0]        channel;
    logic                   sop;
    logic                   eop;
    logic [OUT_EMPTY_W-1:0] empty;
  } st_beat128_t;

endpackage : eth_st_pkg
`default_nettype wire

// File: rtl/eth_double_width_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_double_width_packer_if
// Purpose  : Avalon-ST packet bus bundle (data, valid/ready handshake,
//            channel, SOP, EOP, empty). Width of data and empty are set per
//            instance so the same bundle serves the 64-bit and 128-bit sides.
// Modports : master - drives data/valid/channel/sop/eop/empty, reads ready
//            slave  - reads data/valid/channel/sop/eop/empty, drives ready
// Revision : 1.0 - initial release
// ============================================================================
interface eth_double_width_packer_if
  import eth_st_pkg::*;
#(
  parameter int DATA_W  = IN_W,
  parameter int EMPTY_W = IN_EMPTY_W
) ();

  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               ready;
  logic [CH_W-1:0]    channel;
  logic               startofpacket;
  logic               endofpacket;
  logic [EMPTY_W-1:0] empty;

  modport master (
    output data, valid, channel, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  data, valid, channel, startofpacket, endofpacket, empty,
    output ready
  );

endinterface : eth_double_width_packer_if
`default_nettype wire

// File: rtl/eth_double_width_packer.sv
`default_nettype none
// ============================================================================
// Module   : eth_double_width_packer
// Purpose  : Packs two consecutive 64-bit Avalon-ST beats into one 128-bit
//            beat (earlier beat in the upper half), carrying channel, SOP,
//            EOP and empty. Output is fully registered; at most one
//            half-word is held internally.
// Ports    : clock  - system clock
//            reset  - asynchronous active-high reset
//            in_if  - 64-bit packet input  (slave side, empty 3 bits)
//            out_if - 128-bit packet output (master side, empty 4 bits)
// Revision : 1.0 - initial release
// ============================================================================
module eth_double_width_packer
  import eth_st_pkg::*;
(
  input  wire logic                 clock,
  input  wire logic                 reset,
  eth_double_width_packer_if.slave  in_if,
  eth_double_width_packer_if.master out_if
);

  // Stored first half of a pair
  logic            r_half_full;
  logic [IN_W-1:0] r_half_data;
  logic [CH_W-1:0] r_half_channel;
  logic            r_half_sop;

  // Output beat register
  logic            r_out_valid;
  st_beat128_t     r_out;

  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_pair;
  logic            w_load;
  logic            w_store;
  st_beat128_t     w_next;

  always_comb begin
    w_in_ready = !r_out_valid || out_if.ready;
    w_in_fire  = in_if.valid && w_in_ready;

    // A new SOP arriving while the stored half is a mid-packet beat means the
    // previous packet was cut short: drop the stale half and restart here.
    w_pair  = r_half_full && !(in_if.startofpacket && !r_half_sop);
    w_load  = w_in_fire && (w_pair || in_if.endofpacket);
    w_store = w_in_fire && !w_pair && !in_if.endofpacket;

    w_next = '0;
    if (w_pair) begin
      w_next.data    = {r_half_data, in_if.data};
      w_next.channel = r_half_channel;
      w_next.sop     = r_half_sop;
      w_next.eop     = in_if.endofpacket;
      w_next.empty   = in_if.endofpacket ? {1'b0, in_if.empty} : '0;
    end else begin
      // Lone tail beat: lower half is padding, so 8 more bytes are empty.
      // {1'b1, empty} is empty + 8 for a 3-bit empty.
      w_next.data    = {in_if.data, {IN_W{1'b0}}};
      w_next.channel = in_if.channel;
      w_next.sop     = in_if.startofpacket;
      w_next.eop     = 1'b1;
      w_next.empty   = {1'b1, in_if.empty};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_half_full    <= 1'b0;
      r_half_data    <= '0;
      r_half_channel <= '0;
      r_half_sop     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out          <= '0;
    end else begin
      if (w_in_fire) begin
        r_half_full <= w_store;
      end
      if (w_store) begin
        r_half_data    <= in_if.data;
        r_half_channel <= in_if.channel;
        r_half_sop     <= in_if.startofpacket;
      end
      if (w_load) begin
        r_out       <= w_next;
        r_out_valid <= 1'b1;
      end else if (out_if.ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_if.ready          = w_in_ready;
  assign out_if.valid         = r_out_valid;
  assign out_if.data          = r_out.data;
  assign out_if.channel       = r_out.channel;
  assign out_if.startofpacket = r_out.sop;
  assign out_if.endofpacket   = r_out.eop;
  assign out_if.empty         = r_out.empty;

endmodule : eth_double_width_packer
`default_nettype wire

// File: tb/tb_eth_double_width_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_double_width_packer
// Purpose  : Self-checking bench for eth_double_width_packer. Packets are
//            described as lists of 64-bit beats; the expected 128-bit beats
//            are derived by pairing beats of each packet, and compared with
//            everything the DUT presents on its output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_double_width_packer;
  import eth_st_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_double_width_packer_if #(.DATA_W(IN_W),  .EMPTY_W(IN_EMPTY_W))  in_if ();
  eth_double_width_packer_if #(.DATA_W(OUT_W), .EMPTY_W(OUT_EMPTY_W)) out_if ();

  eth_double_width_packer dut (
    .clock  (clk),
    .reset  (rst),
    .in_if  (in_if),
    .out_if (out_if)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  st_beat128_t exp_q[$];
  logic [63:0] pkt[16];
  int          rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected output: beats of a packet taken two at a time, earlier beat on
  // top; an odd last beat is padded with zeros and gains 8 empty bytes.
  // A packet without EOP only yields its complete pairs.
  task automatic model_packet(input int n, input logic [CH_W-1:0] ch,
                              input logic [2:0] e, input bit has_eop);
    int pairs;
    pairs = has_eop ? (n + 1) / 2 : n / 2;
    for (int i = 0; i < pairs; i++) begin
      st_beat128_t b;
      b.data[127:64] = pkt[2*i];
      b.data[63:0]   = (2*i + 1 < n) ? pkt[2*i+1] : 64'h0;
      b.channel      = ch;
      b.sop          = (i == 0);
      b.eop          = has_eop && (i == pairs - 1);
      b.empty        = b.eop ? ((n % 2 == 1) ? 4'(e) + 4'd8 : 4'(e)) : 4'd0;
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat's transfer edge.
  task automatic drive_beat(input logic [63:0] d, input logic [CH_W-1:0] ch,
                            input logic sop, input logic eop,
                            input logic [2:0] e, input bit gap);
    int t;
    bit fired;
    if (gap) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    in_if.valid         = 1'b1;
    in_if.data          = d;
    in_if.channel       = ch;
    in_if.startofpacket = sop;
    in_if.endofpacket   = eop;
    in_if.empty         = e;
    fired = 1'b0;
    t = 0;
    while (!fired && t < 1000) begin
      @(negedge clk);
      fired = in_if.ready;
      @(posedge clk); #1;
      t++;
    end
    if (!fired) check("in_ready_timeout", 128'(in_if.ready), 128'(1));
    in_if.valid         = 1'b0;
    in_if.data          = {$urandom, $urandom};
    in_if.startofpacket = 1'($urandom_range(0, 1));
    in_if.endofpacket   = 1'($urandom_range(0, 1));
    in_if.empty         = 3'($urandom_range(0, 7));
  endtask

  task automatic send_packet(input int n, input logic [CH_W-1:0] ch,
                             input logic [2:0] e, input bit has_eop, input bit gap);
    for (int i = 0; i < n; i++) pkt[i] = {$urandom, $urandom};
    model_packet(n, ch, e, has_eop);
    for (int i = 0; i < n; i++) begin
      logic last;
      last = has_eop && (i == n - 1);
      // empty on non-EOP beats is junk that must be ignored
      drive_beat(pkt[i], ch, (i == 0), last,
                 last ? e : 3'($urandom_range(0, 7)), gap);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  // out_ready changes only just after rising edges
  initial begin
    out_if.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_if.ready = 1'b0;
        1:       out_if.ready = 1'b1;
        default: out_if.ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Every presented output beat must equal the head of the expected queue
  // (so held beats are also checked for stability); pop on transfer.
  always @(negedge clk) begin
    if (!rst && out_if.valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 128'(out_if.valid), 128'(0));
      end else begin
        check("out_data",    out_if.data,                  exp_q[0].data);
        check("out_channel", 128'(out_if.channel),         128'(exp_q[0].channel));
        check("out_sop",     128'(out_if.startofpacket),   128'(exp_q[0].sop));
        check("out_eop",     128'(out_if.endofpacket),     128'(exp_q[0].eop));
        check("out_empty",   128'(out_if.empty),           128'(exp_q[0].empty));
        if (out_if.ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                 = 1'b1;
    in_if.valid         = 1'b0;
    in_if.data          = '0;
    in_if.channel       = '0;
    in_if.startofpacket = 1'b0;
    in_if.endofpacket   = 1'b0;
    in_if.empty         = '0;
    rdy_mode            = 1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(out_if.valid),         128'(0));
    check("rst_out_data",  out_if.data,                128'(0));
    check("rst_out_ch",    128'(out_if.channel),       128'(0));
    check("rst_out_sop",   128'(out_if.startofpacket), 128'(0));
    check("rst_out_eop",   128'(out_if.endofpacket),   128'(0));
    check("rst_out_empty", 128'(out_if.empty),         128'(0));
    check("rst_in_ready",  128'(in_if.ready),          128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Even, odd and single-beat packets with free-flowing output
    send_packet(6, 10'd3, 3'd5, 1'b1, 1'b0);
    drain();
    send_packet(5, 10'd3, 3'd2, 1'b1, 1'b0);
    drain();
    send_packet(1, 10'd9, 3'd0, 1'b1, 1'b0);
    drain();

    // Back-to-back packets on different channels
    send_packet(4, 10'd1, 3'd7, 1'b1, 1'b0);
    send_packet(3, 10'd2, 3'd4, 1'b1, 1'b0);
    drain();

    // Backpressure: pending output with out_ready low for 5 cycles
    rdy_mode = 0;
    @(posedge clk); #1;
    send_packet(2, 10'd7, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready",  128'(in_if.ready),  128'(0));
      check("bp_out_valid", 128'(out_if.valid), 128'(1));
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    send_packet(3, 10'd8, 3'd6, 1'b1, 1'b0);
    drain();

    // Truncated packet (3 beats, no EOP) followed by a fresh SOP: the
    // stranded third beat is dropped and the new packet packs normally.
    send_packet(3, 10'd11, 3'd0, 1'b0, 1'b0);
    send_packet(4, 10'd12, 3'd3, 1'b1, 1'b0);
    drain();

    // Asynchronous reset with an output beat pending
    rdy_mode = 0;
    @(posedge clk); #1;
    send_packet(2, 10'd5, 3'd2, 1'b1, 1'b0);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_out_valid", 128'(out_if.valid), 128'(0));
    check("arst_out_data",  out_if.data,        128'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rdy_mode = 1;

    // Asynchronous reset with a first half stored (SOP beat)
    drive_beat({$urandom, $urandom}, 10'd6, 1'b1, 1'b0, 3'd0, 1'b0);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_packet(4, 10'd13, 3'd1, 1'b1, 1'b0);
    drain();

    // Random traffic with random backpressure
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      send_packet($urandom_range(1, 8), 10'($urandom_range(0, 1023)),
                  3'($urandom_range(0, 7)), 1'b1, 1'b1);
    end
    rdy_mode = 1;
    drain();
    repeat (2) @(negedge clk);
    check("end_out_valid", 128'(out_if.valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_eth_double_width_packer
`default_nettype wire

// File: doc/eth_double_width_packer.md
Name: eth_double_width_packer

Overview:
Avalon-ST width converter: packs two consecutive 64-bit packet beats into one 128-bit beat, carrying channel, SOP, EOP and empty. Sits between each 64-bit per-port packet source and the 4-to-1 128-bit ingress mux. One instance per Ethernet port. Fully registered output; no packet buffering beyond one half-word.

Parameters:
IN_W, 64, input data width (symbols are bytes; 8 per input beat)
CH_W, 10, channel width
OUT_EMPTY_W, 4, output empty width (log2 of 16 bytes)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_data  in  64  input beat; first byte in bits [63:56]
in_valid  in  1  input beat valid
in_ready  out  1  input may transfer this cycle
in_channel  in  10  channel, sampled on the first beat of each pair
in_startofpacket  in  1  first beat of packet
in_endofpacket  in  1  last beat of packet
in_empty  in  3  unused bytes on EOP beat
out_data  out  128  packed beat; earlier 64-bit beat in [127:64]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_channel  out  10  channel of the packed beat
out_startofpacket  out  1  SOP of packed beat
out_endofpacket  out  1  EOP of packed beat
out_empty  out  4  unused bytes on EOP beat

Behaviour:
- Transfer rules: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- in_ready = !out_valid | out_ready. It is combinational from out_ready and the registered out_valid.
- State: half_full flag plus half register {data 64, channel, sop}. out_* are registers.
- Reset values: half_full=0, out_valid=0, out_data=0, out_channel=0, out_sop=0, out_eop=0, out_empty=0.
- Accept with half_full=0 and in_eop=0: store in_data, in_channel and in_sop into the half register. Set half_full=1. No output is produced.
- Accept with half_full=0 and in_eop=1 (odd-length tail or 1-beat packet), output registers load next edge with:
  - data = {in_data, 64'b0}
  - channel = in_channel
  - sop = in_sop, eop = 1
  - empty = in_empty + 8
- Accept with half_full=1, output registers load next edge with:
  - data = {half_data, in_data}
  - channel = half_channel
  - sop = half_sop
  - eop = in_eop
  - empty = in_eop ? {1'b0, in_empty} : 0
  - Then half_full clears.
- Latency: one cycle from the completing input beat to out_valid. Throughput is one output beat per two input beats.
- Output hold: out_valid and all out_* stay stable until an output transfer. After a transfer with no new load, out_valid drops to 0.
- Simultaneous output transfer and new load: the new beat replaces the old one; out_valid stays 1.
- Protocol recovery: in_sop accepted while half_full=1 and half_sop=0 drops the stored half. The new beat is treated as a first half, or as a single tail if in_eop=1.
- in_empty is ignored on non-EOP beats. out_empty is 0 on non-EOP beats.
- Asynchronous reset mid-packet discards the stored half and any pending output beat.

Decomposition:
- Shared package eth_st_pkg holds: IN_W, CH_W and the empty widths, plus a packed struct st_beat_t {data, channel, sop, eop, empty} for 64-bit and 128-bit variants.
- No sub-module. A single always_ff block with a small combinational next-state block is sufficient.

Test Plan:
- Reset: assert reset asynchronously mid-stream -> out_valid=0 and half_full=0 immediately; the next packet packs from its first beat.
- Even packet: 6 beats D0..D5, channel 3, in_empty=5 on D5, out_ready=1 -> 3 outputs:
  - {D0,D1} sop=1, channel=3
  - {D2,D3}
  - {D4,D5} eop=1, empty=5
- Odd packet: 5 beats D0..D4, in_empty=2 on D4 -> third output {D4,64'h0}, eop=1, empty=10, sop=0.
- Single-beat packet: sop=eop=1, in_empty=0 -> one output with sop=1, eop=1, empty=8, data low half 0.
- Backpressure: out_ready held 0 for 5 cycles with an output pending -> in_ready=0 and out_* stable. On release, the stream continues with no loss or duplication. Random out_ready over 1000 packets -> reassembled byte stream matches input.
- Back-to-back packets on channels 1 then 2 -> each output carries its own first-beat channel; the second packet's sop aligns to bits [127:64].
